// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB first as a + ~b + 1,
// with the carry held in a single flop between bits and valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             s;
  logic             c_next;

  // Full adder fed with the inverted subtrahend bit; returns {carry_out, sum}.
  function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic cin);
    logic yn;
    yn = ~y;
    return {(x & yn) | (cin & (x ^ yn)), x ^ yn ^ cin};
  endfunction

  assign {c_next, s} = sub_bit(sa[0], sb[0], c);

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      c        <= 1'b1;
      cnt      <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            sa    <= a;
            sb    <= b;
            c     <= 1'b1;
            cnt   <= '0;
            diff  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so bit 0 reaches diff[0] after WIDTH shifts.
          diff <= {s, diff[WIDTH-1:1]};
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          c    <= c_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            overflow <= c ^ c_next;
            borrow   <= ~c_next;
            state    <= DONE;
          end
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, backpressure and
// mid-run reset sequences, random 8-bit pairs, and an exhaustive 4-bit instance.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       overflow;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc8 = 0;
  int acc4 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       sv8 = 1'b0, rr8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       sr8, rv8, bo8, ov8, busy8;
  logic [7:0] d8;

  logic       sv4 = 1'b0, rr4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic       sr4, rv4, bo4, ov4, busy4;
  logic [3:0] d4;

  vec_t q8[$];
  vec_t q4[$];
  vec_t tbl[9];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8),
    .result_valid(rv8), .result_ready(rr8), .diff(d8), .borrow(bo8), .overflow(ov8),
    .busy(busy8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4), .a(a4), .b(b4),
    .result_valid(rv4), .result_ready(rr4), .diff(d4), .borrow(bo4), .overflow(ov4),
    .busy(busy4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain w-bit arithmetic on zero-extended operands.
  function automatic vec_t model(input int w, input logic [7:0] x, input logic [7:0] y);
    vec_t e;
    logic [7:0] m;
    m = 8'((1 << w) - 1);
    e.a = x;
    e.b = y;
    e.diff = (x - y) & m;
    e.borrow = (x < y);
    e.overflow = (x[w-1] != y[w-1]) && (e.diff[w-1] != x[w-1]);
    return e;
  endfunction

  task automatic op8(input vec_t v);
    int n;
    n = 0;
    while (!sr8 && n < 40) begin @(posedge clk); #1; n++; end
    if (!sr8) begin chk("accept_timeout8", 0, 1); return; end
    a8 = v.a; b8 = v.b; sv8 = 1'b1;
    q8.push_back(v);
    @(posedge clk); #1;
    acc8 = cyc;
    sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic op4(input vec_t v);
    int n;
    n = 0;
    while (!sr4 && n < 40) begin @(posedge clk); #1; n++; end
    if (!sr4) begin chk("accept_timeout4", 0, 1); return; end
    a4 = v.a[3:0]; b4 = v.b[3:0]; sv4 = 1'b1;
    q4.push_back(v);
    @(posedge clk); #1;
    acc4 = cyc;
    sv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while ((q8.size() != 0 || !sr8) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain8", q8.size(), 0);
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while ((q4.size() != 0 || !sr4) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain4", q4.size(), 0);
  endtask

  initial begin : mon8
    logic prev;
    vec_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (rv8 && !prev) chk("latency8", cyc - acc8, 8);
        prev = rv8;
        if (rv8 && rr8) begin
          if (q8.size() == 0) chk("unexpected_result8", 1, 0);
          else begin
            e = q8.pop_front();
            chk($sformatf("diff8 %h-%h", e.a, e.b), d8, e.diff);
            chk($sformatf("borrow8 %h-%h", e.a, e.b), bo8, e.borrow);
            chk($sformatf("overflow8 %h-%h", e.a, e.b), ov8, e.overflow);
          end
        end
      end
    end
  end

  initial begin : mon4
    logic prev;
    vec_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (rv4 && !prev) chk("latency4", cyc - acc4, 4);
        prev = rv4;
        if (rv4 && rr4) begin
          if (q4.size() == 0) chk("unexpected_result4", 1, 0);
          else begin
            e = q4.pop_front();
            chk($sformatf("diff4 %h-%h", e.a, e.b), d4, e.diff[3:0]);
            chk($sformatf("borrow4 %h-%h", e.a, e.b), bo4, e.borrow);
            chk($sformatf("overflow4 %h-%h", e.a, e.b), ov4, e.overflow);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    tbl[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", sr8, 1);
    chk("rst_result_valid", rv8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_diff", d8, 0);
    chk("rst_borrow", bo8, 0);
    chk("rst_overflow", ov8, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First vector walked by hand for exact latency and ready return
    op8(tbl[0]);
    chk("busy_in_run", busy8, 1);
    chk("ready_in_run", sr8, 0);
    repeat (7) @(posedge clk);
    #1;
    chk("valid_before_8", rv8, 0);
    @(posedge clk); #1;
    chk("valid_at_8", rv8, 1);
    chk("busy_in_done", busy8, 1);
    @(posedge clk); #1;
    chk("ready_after_consume", sr8, 1);
    chk("valid_after_consume", rv8, 0);

    for (int i = 1; i < 9; i++) op8(tbl[i]);
    drain8();

    // Backpressure with start_valid pulsing in DONE
    rr8 = 1'b0;
    op8('{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1});
    for (int n = 0; n < 20 && !rv8; n++) begin @(posedge clk); #1; end
    chk("bp_valid", rv8, 1);
    for (int k = 0; k < 5; k++) begin
      sv8 = k[0] ? 1'b0 : 1'b1;
      a8 = 8'h33; b8 = 8'h44;
      @(posedge clk); #1;
      chk("bp_diff", d8, 8'h7F);
      chk("bp_borrow", bo8, 0);
      chk("bp_overflow", ov8, 1);
      chk("bp_start_ready", sr8, 0);
      chk("bp_result_valid", rv8, 1);
    end
    sv8 = 1'b1;
    rr8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_release", sr8, 1);
    op8('{8'h33, 8'h44, 8'hEF, 1'b1, 1'b0});
    drain8();

    // Reset during RUN bit 3
    op8('{8'h55, 8'h12, 8'h43, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_start_ready", sr8, 1);
    chk("midrst_result_valid", rv8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_diff", d8, 0);
    chk("midrst_borrow", bo8, 0);
    chk("midrst_overflow", ov8, 0);
    q8.delete();
    @(posedge clk); #1;
    chk("midrst_hold_valid", rv8, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) op8('{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0});
      if (rv8 && q8.size() == 0) chk("midrst_stray_valid", rv8, 0);
    end
    drain8();

    // Random 8-bit pairs
    for (int i = 0; i < 1500; i++) op8(model(8, 8'($urandom), 8'($urandom)));
    drain8();

    // Exhaustive 4-bit
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op4(model(4, 8'(x), 8'(y)));
    drain4();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
